// File: rtl/npu_pkg.sv
// Shared types and helpers for the tile scheduler: state encoding, read-pipe slot, ceil_div.
package npu_pkg;

    localparam int TILE_MAX = 16;
    localparam int IDX_W    = $clog2(TILE_MAX * TILE_MAX);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        NPU     = 3'd2,
        STORE   = 3'd3,
        ADVANCE = 3'd4,
        HOLD    = 3'd5,
        FINISH  = 3'd6
    } sched_state_t;

    typedef struct packed {
        logic             vld;
        logic             inb;
        logic [IDX_W-1:0] idx;
    } rd_slot_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/tile_read_pipe.sv
// Delays each issued read slot by RD_LAT cycles so the capture strobe lines up with src_data.
module tile_read_pipe
    import npu_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  rd_slot_t slot_in,
    output rd_slot_t slot_out
);

    rd_slot_t stage [RD_LAT];

    // flush drops in-flight slots so a restarted LOAD never sees stale captures
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= flush ? '0 : slot_in;
            for (int i = 1; i < RD_LAT; i++) stage[i] <= flush ? '0 : stage[i-1];
        end
    end

    assign slot_out = stage[RD_LAT-1];

endmodule

// File: rtl/tile_scheduler.sv
// Raster-order tile sequencer: loads a zero-padded tile from the source ROM, runs the NPU,
// and writes the in-image part of the result back to the destination RAM.
module tile_scheduler
    import npu_pkg::*;
#(
    parameter int IMG_W  = 400,
    parameter int IMG_H  = 400,
    parameter int TILE   = 10,
    parameter int PIX_W  = 8,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 18
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        go,
    input  logic                        step,
    input  logic                        abort,
    output logic [ADDR_W-1:0]           src_addr,
    output logic                        src_rd,
    input  logic [PIX_W-1:0]            src_data,
    output logic [TILE*TILE*16-1:0]     tile_in,
    output logic                        npu_start,
    input  logic                        npu_done,
    input  logic [TILE*TILE*PIX_W-1:0]  tile_out,
    output logic [ADDR_W-1:0]           dst_addr,
    output logic [PIX_W-1:0]            dst_data,
    output logic                        dst_we,
    output logic                        busy,
    output logic                        done,
    output logic [7:0]                  tile_x,
    output logic [7:0]                  tile_y,
    output logic [2:0]                  state_o,
    output logic [31:0]                 mem_access,
    output logic [31:0]                 npu_cycles
);

    localparam int NPIX  = TILE * TILE;
    localparam int TX    = ceil_div(IMG_W, TILE);
    localparam int TY    = ceil_div(IMG_H, TILE);
    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] NPIX_C     = CNT_W'(NPIX);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(NPIX + RD_LAT - 1);
    localparam logic [CNT_W-1:0] STORE_LAST = CNT_W'(NPIX - 1);

    sched_state_t state, next;
    logic                       step_mode, abort_pend;
    logic [CNT_W-1:0]           cnt;
    logic [4:0]                 row, col;
    logic [NPIX-1:0][PIX_W-1:0] pix_buf;
    logic                       issue, inb, last_tile;
    logic [ADDR_W-1:0]          pix_addr;
    logic [PIX_W-1:0]           sel_pix;
    int                         x_pos, y_pos;
    rd_slot_t                   slot_in, slot_cap;

    // row/col walk the tile row-major in both LOAD (issue side) and STORE
    always_comb begin
        x_pos    = int'(tile_x) * TILE + int'(col);
        y_pos    = int'(tile_y) * TILE + int'(row);
        inb      = (x_pos < IMG_W) && (y_pos < IMG_H);
        pix_addr = ADDR_W'(y_pos * IMG_W + x_pos);
    end

    assign issue     = (state == LOAD) && (cnt < NPIX_C);
    assign src_rd    = issue && inb && !abort;
    assign src_addr  = pix_addr;
    assign last_tile = (tile_x == 8'(TX - 1)) && (tile_y == 8'(TY - 1));
    assign busy      = (state != IDLE);
    assign state_o   = state;

    assign slot_in = '{vld: issue, inb: inb, idx: IDX_W'(cnt)};

    tile_read_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (state != LOAD),
        .slot_in  (slot_in),
        .slot_out (slot_cap)
    );

    always_comb begin
        sel_pix = '0;
        for (int i = 0; i < NPIX; i++)
            if (cnt == CNT_W'(i)) sel_pix = tile_out[i*PIX_W +: PIX_W];
    end

    for (genvar i = 0; i < NPIX; i++) begin : g_tin
        assign tile_in[i*16 +: 16] = 16'(pix_buf[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next      = state;
        npu_start = 1'b0;
        case (state)
            IDLE:    if (go || step) next = LOAD;
            LOAD:    if (abort) next = IDLE;
                     else if (cnt == LOAD_LAST) next = NPU;
            NPU: begin
                npu_start = (cnt == '0);
                // an abort seen during NPU only takes effect once the core is done
                if (npu_done) next = (abort || abort_pend) ? IDLE : STORE;
            end
            STORE:   if (abort) next = IDLE;
                     else if (cnt == STORE_LAST) next = ADVANCE;
            ADVANCE: if (abort) next = IDLE;
                     else if (last_tile) next = FINISH;
                     else next = step_mode ? HOLD : LOAD;
            HOLD:    if (abort) next = IDLE;
                     else if (go || step) next = LOAD;
            FINISH:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Out-of-image slots carry inb=0 through the pipe and load a zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_buf <= '0;
        end else begin
            for (int i = 0; i < NPIX; i++)
                if (slot_cap.vld && slot_cap.idx == IDX_W'(i))
                    pix_buf[i] <= slot_cap.inb ? src_data : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_mode  <= 1'b0;
            abort_pend <= 1'b0;
            done       <= 1'b0;
            tile_x     <= '0;
            tile_y     <= '0;
            cnt        <= '0;
            row        <= '0;
            col        <= '0;
            mem_access <= '0;
            npu_cycles <= '0;
            dst_we     <= 1'b0;
            dst_addr   <= '0;
            dst_data   <= '0;
        end else begin
            dst_we <= 1'b0;
            case (state)
                IDLE: if (go || step) begin
                    step_mode  <= ~go;
                    done       <= 1'b0;
                    abort_pend <= 1'b0;
                    tile_x     <= '0;
                    tile_y     <= '0;
                    cnt        <= '0;
                    row        <= '0;
                    col        <= '0;
                    mem_access <= '0;
                    npu_cycles <= '0;
                end
                LOAD: begin
                    if (src_rd) mem_access <= mem_access + 32'd1;
                    if (issue) begin
                        if (col == 5'(TILE - 1)) begin
                            col <= '0;
                            row <= row + 5'd1;
                        end else begin
                            col <= col + 5'd1;
                        end
                    end
                    if (next == NPU) begin
                        cnt <= '0;
                        row <= '0;
                        col <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                NPU: begin
                    npu_cycles <= npu_cycles + 32'd1;
                    cnt        <= CNT_W'(1);
                    if (abort) abort_pend <= 1'b1;
                    if (npu_done) begin
                        cnt        <= '0;
                        abort_pend <= 1'b0;
                    end
                end
                STORE: begin
                    if (inb && !abort) begin
                        dst_we     <= 1'b1;
                        dst_addr   <= pix_addr;
                        dst_data   <= sel_pix;
                        mem_access <= mem_access + 32'd1;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (col == 5'(TILE - 1)) begin
                        col <= '0;
                        row <= row + 5'd1;
                    end else begin
                        col <= col + 5'd1;
                    end
                end
                ADVANCE: if (!abort && !last_tile) begin
                    if (tile_x == 8'(TX - 1)) begin
                        tile_x <= '0;
                        tile_y <= tile_y + 8'd1;
                    end else begin
                        tile_x <= tile_x + 8'd1;
                    end
                    cnt <= '0;
                    row <= '0;
                    col <= '0;
                end
                HOLD: if (!abort && go) step_mode <= 1'b0;
                FINISH: begin
                    done      <= 1'b1;
                    step_mode <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler on a 25x20 image, 10x10 tiles, 3-cycle ROM latency.
module tb_tile_scheduler;
    import npu_pkg::*;

    localparam int W = 25, H = 20, T = 10, PW = 8, RL = 3, AW = 18, NP = T * T;
    localparam int TXN = 3, TYN = 2;

    logic              clk = 1'b0;
    logic              rst, go, step, abort;
    logic [AW-1:0]     src_addr, dst_addr;
    logic              src_rd, npu_start, dst_we, busy, done;
    logic              npu_done = 1'b0;
    logic [PW-1:0]     src_data, dst_data;
    logic [NP*16-1:0]  tile_in;
    logic [NP*PW-1:0]  tile_out;
    logic [7:0]        tile_x, tile_y;
    logic [2:0]        state_o;
    logic [31:0]       mem_access, npu_cycles;

    typedef struct {
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    int n_cmp = 0, n_bad = 0, wr_cnt = 0;

    always #5 clk = ~clk;

    tile_scheduler #(.IMG_W(W), .IMG_H(H), .TILE(T), .PIX_W(PW), .RD_LAT(RL), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .go(go), .step(step), .abort(abort),
        .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
        .tile_in(tile_in), .npu_start(npu_start), .npu_done(npu_done), .tile_out(tile_out),
        .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
        .busy(busy), .done(done), .tile_x(tile_x), .tile_y(tile_y), .state_o(state_o),
        .mem_access(mem_access), .npu_cycles(npu_cycles)
    );

    function automatic logic [PW-1:0] rom(input logic [AW-1:0] a);
        return PW'(a * 7 + (a >> 5) + 1);
    endfunction

    // ROM with RL-cycle read latency; 0xEE marks "no read issued"
    logic [RL-1:0] rv = '0;
    logic [AW-1:0] ra [RL];
    always @(posedge clk) begin
        rv    <= {rv[RL-2:0], src_rd};
        ra[0] <= src_addr;
        for (int i = 1; i < RL; i++) ra[i] <= ra[i-1];
    end
    assign src_data = rv[RL-1] ? rom(ra[RL-1]) : 8'hEE;

    // NPU echoes its input; npu_done pulses 5 cycles after npu_start
    int ncnt = 0;
    always @(posedge clk) begin
        if (npu_start) begin
            ncnt     <= 4;
            npu_done <= 1'b0;
        end else begin
            npu_done <= (ncnt == 1);
            if (ncnt != 0) ncnt <= ncnt - 1;
        end
    end
    for (genvar i = 0; i < NP; i++) begin : g_echo
        assign tile_out[i*PW +: PW] = tile_in[i*16 +: PW];
    end

    function automatic logic [NP*16-1:0] exp_tile(input int tx, input int ty);
        logic [NP*16-1:0] v = '0;
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++) begin
                int x = tx * T + c, y = ty * T + r;
                if (x < W && y < H) v[(r*T+c)*16 +: 16] = 16'(rom(AW'(y * W + x)));
            end
        return v;
    endfunction

    task automatic push_tile(input int tx, input int ty, input int limit);
        int n = 0;
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++) begin
                int x = tx * T + c, y = ty * T + r;
                if (x < W && y < H && n < limit) begin
                    exp_q.push_back('{addr: AW'(y * W + x), data: rom(AW'(y * W + x))});
                    n++;
                end
            end
    endtask

    task automatic push_tiles(input int from_idx);
        for (int k = from_idx; k < TXN * TYN; k++) push_tile(k % TXN, k / TXN, NP);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (state_o != s && n < 3000) begin
            tick();
            n++;
        end
        chk(name, 32'(state_o), 32'(s));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 5000) begin
            tick();
            n++;
        end
        chk(name, 32'(done), 1);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (dst_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", 32'(dst_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e = exp_q.pop_front();
                    chk("dst_addr", 32'(dst_addr), 32'(e.addr));
                    chk("dst_data", 32'(dst_data), 32'(e.data));
                end
            end
            if (npu_start) begin
                logic [NP*16-1:0] e = exp_tile(int'(tile_x), int'(tile_y));
                int bad = -1;
                for (int i = NP - 1; i >= 0; i--)
                    if (tile_in[i*16 +: 16] !== e[i*16 +: 16]) bad = i;
                n_cmp++;
                if (bad >= 0) begin
                    n_bad++;
                    $display("FAIL tile_in(%0d,%0d) elem %0d: got %0h, expected %0h",
                             tile_x, tile_y, bad, tile_in[bad*16 +: 16], e[bad*16 +: 16]);
                end
            end
        end
    endtask

    initial begin
        int base, n_load;
        rst = 1'b0; go = 1'b0; step = 1'b0; abort = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) tick();

        // reset state
        chk("rst_state", 32'(state_o), 32'(IDLE));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dst_we", 32'(dst_we), 0);
        chk("rst_src_rd", 32'(src_rd), 0);
        chk("rst_mem_access", mem_access, 0);
        chk("rst_tile_in_nz", 32'(tile_in != '0), 0);
        rst = 1'b1;
        tick();

        // continuous run with padded right-column tiles
        base = wr_cnt;
        push_tiles(0);
        go = 1'b1; tick(); go = 1'b0;
        n_load = 0;
        while (state_o == 3'(LOAD) && n_load < 500) begin
            tick();
            n_load++;
        end
        chk("load_cycles", 32'(n_load), 103);
        wait_done("run1_done");
        chk("run1_busy", 32'(busy), 0);
        chk("run1_writes", 32'(wr_cnt - base), 500);
        chk("run1_mem_access", mem_access, 1000);
        chk("run1_npu_cycles", npu_cycles, 36);
        chk("run1_queue_left", 32'(exp_q.size()), 0);

        // step mode: one tile per step, then go finishes the rest
        base = wr_cnt;
        push_tile(0, 0, NP);
        step = 1'b1; tick(); step = 1'b0;
        chk("step_done_cleared", 32'(done), 0);
        wait_state(3'(HOLD), "step1_hold");
        chk("step1_writes", 32'(wr_cnt - base), 100);
        chk("step1_busy", 32'(busy), 1);
        chk("step1_tile_x", 32'(tile_x), 1);
        push_tile(1, 0, NP);
        step = 1'b1; tick(); step = 1'b0;
        wait_state(3'(HOLD), "step2_hold");
        chk("step2_writes", 32'(wr_cnt - base), 200);
        push_tiles(2);
        go = 1'b1; tick(); go = 1'b0;
        wait_done("step_run_done");
        chk("step_run_writes", 32'(wr_cnt - base), 500);
        chk("step_run_mem_access", mem_access, 1000);
        chk("step_run_queue_left", 32'(exp_q.size()), 0);

        // abort during STORE at index 37: indices 0..36 written only
        base = wr_cnt;
        push_tile(0, 0, 37);
        go = 1'b1; tick(); go = 1'b0;
        wait_state(3'(STORE), "abort_st_reach");
        repeat (37) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_st_dst_we", 32'(dst_we), 0);
        chk("abort_st_state", 32'(state_o), 32'(IDLE));
        chk("abort_st_done", 32'(done), 0);
        repeat (3) tick();
        chk("abort_st_writes", 32'(wr_cnt - base), 37);
        chk("abort_st_queue_left", 32'(exp_q.size()), 0);

        // abort during NPU: waits for npu_done, then IDLE with no writes
        base = wr_cnt;
        go = 1'b1; tick(); go = 1'b0;
        wait_state(3'(NPU), "abort_npu_reach");
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_npu_hold1", 32'(state_o), 32'(NPU));
        repeat (4) tick();
        chk("abort_npu_hold5", 32'(state_o), 32'(NPU));
        tick();
        chk("abort_npu_idle", 32'(state_o), 32'(IDLE));
        repeat (3) tick();
        chk("abort_npu_writes", 32'(wr_cnt - base), 0);
        chk("abort_npu_done", 32'(done), 0);

        // reset asserted mid-LOAD
        go = 1'b1; tick(); go = 1'b0;
        repeat (20) tick();
        rst = 1'b0;
        #1;
        chk("midrst_state", 32'(state_o), 32'(IDLE));
        chk("midrst_src_rd", 32'(src_rd), 0);
        chk("midrst_src_addr", 32'(src_addr), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_mem_access", mem_access, 0);
        chk("midrst_tile_in_nz", 32'(tile_in != '0), 0);
        tick();
        rst = 1'b1;
        tick();

        // go and step together: go wins, continuous run from tile (0,0)
        base = wr_cnt;
        push_tiles(0);
        go = 1'b1; step = 1'b1; tick(); go = 1'b0; step = 1'b0;
        chk("restart_state", 32'(state_o), 32'(LOAD));
        chk("restart_tile", 32'({tile_y, tile_x}), 0);
        wait_done("run2_done");
        chk("run2_writes", 32'(wr_cnt - base), 500);
        chk("run2_mem_access", mem_access, 1000);
        chk("run2_npu_cycles", npu_cycles, 36);
        chk("run2_queue_left", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
